// File: rtl/fixed_signed_cast_skid_if.sv
// Handshake bundle for the fixed-point cast skid stage: upstream value in, cast value out.
// The DUT uses the slave modport; the producer/consumer side uses master.
interface fixed_signed_cast_skid_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 8
) ();
  logic [IN_WIDTH-1:0]  data_in;
  logic                 data_in_valid;
  logic                 data_in_ready;
  logic [OUT_WIDTH-1:0] data_out;
  logic                 data_out_valid;
  logic                 data_out_ready;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_signed_cast_skid.sv
// Purpose: signed fixed-point width/fraction cast (floor or round-half-up, saturating) into a 2-entry skid buffer.
// Latency: 1 cycle from input transfer to data_out; full throughput with data_out_ready held high.
// Backpressure: holds up to 2 results; data_in_ready is a register that falls only when the skid entry fills.
module fixed_signed_cast_skid #(
  parameter int IN_WIDTH       = 8,
  parameter int IN_FRAC_WIDTH  = 4,
  parameter int OUT_WIDTH      = 8,
  parameter int OUT_FRAC_WIDTH = 4,
  parameter bit SYMMETRIC      = 1'b0,
  parameter bit ROUND_FLOOR    = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  fixed_signed_cast_skid_if.slave io
);

  localparam int SHL  = (OUT_FRAC_WIDTH >= IN_FRAC_WIDTH) ? (OUT_FRAC_WIDTH - IN_FRAC_WIDTH) : 0;
  localparam int SHR  = (IN_FRAC_WIDTH > OUT_FRAC_WIDTH) ? (IN_FRAC_WIDTH - OUT_FRAC_WIDTH) : 0;
  localparam int WMAX = (IN_WIDTH > OUT_WIDTH) ? IN_WIDTH : OUT_WIDTH;
  localparam int W    = WMAX + SHL + SHR + 2;

  localparam logic signed [W-1:0] ONE  = W'(1);
  localparam logic signed [W-1:0] MAXV = (ONE <<< (OUT_WIDTH - 1)) - ONE;
  localparam logic signed [W-1:0] MINV = SYMMETRIC ? -MAXV : (-MAXV - ONE);
  // Half an output LSB, only when rounding and bits are actually dropped.
  localparam logic signed [W-1:0] RND  = (!ROUND_FLOOR) ? ((ONE << SHR) >> 1) : '0;

  logic signed [W-1:0]  ext;
  logic signed [W-1:0]  shifted;
  logic [OUT_WIDTH-1:0] cast_dat;

  always_comb begin
    ext      = {{(W-IN_WIDTH){io.data_in[IN_WIDTH-1]}}, io.data_in};
    shifted  = ((ext + RND) <<< SHL) >>> SHR;
    cast_dat = shifted[OUT_WIDTH-1:0];
    if (shifted > MAXV) begin
      cast_dat = MAXV[OUT_WIDTH-1:0];
    end else if (shifted < MINV) begin
      cast_dat = MINV[OUT_WIDTH-1:0];
    end
  end

  logic                 main_vld;
  logic [OUT_WIDTH-1:0] main_dat;
  logic                 skid_vld;
  logic [OUT_WIDTH-1:0] skid_dat;
  logic                 in_rdy_q;
  logic                 in_xfer;
  logic                 out_xfer;

  assign in_xfer  = io.data_in_valid & in_rdy_q;
  assign out_xfer = main_vld & io.data_out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      main_vld <= 1'b0;
      main_dat <= '0;
      skid_vld <= 1'b0;
      skid_dat <= '0;
      in_rdy_q <= 1'b1;
    end else if (out_xfer) begin
      if (skid_vld) begin
        // in_rdy_q is low here, so no input can arrive in the same cycle.
        main_dat <= skid_dat;
        skid_vld <= 1'b0;
        in_rdy_q <= 1'b1;
      end else if (in_xfer) begin
        main_dat <= cast_dat;
      end else begin
        main_vld <= 1'b0;
      end
    end else if (in_xfer) begin
      if (!main_vld) begin
        main_dat <= cast_dat;
        main_vld <= 1'b1;
      end else begin
        skid_dat <= cast_dat;
        skid_vld <= 1'b1;
        in_rdy_q <= 1'b0;
      end
    end
  end

  assign io.data_in_ready  = in_rdy_q;
  assign io.data_out       = main_dat;
  assign io.data_out_valid = main_vld;

endmodule

// File: tb/tb_fixed_signed_cast_skid.sv
// Directed bench: five cast configurations checked from a vector table, then skid/backpressure
// and mid-stream reset sequences on the identity instance.
module tb_fixed_signed_cast_skid;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 0 identity 8/4->8/4, 1 narrow floor 8/4->4/2, 2 narrow round, 3 narrow symmetric, 4 widen 4/2->8/4
  fixed_signed_cast_skid_if #(.IN_WIDTH(8), .OUT_WIDTH(8)) if0 ();
  fixed_signed_cast_skid_if #(.IN_WIDTH(8), .OUT_WIDTH(4)) if1 ();
  fixed_signed_cast_skid_if #(.IN_WIDTH(8), .OUT_WIDTH(4)) if2 ();
  fixed_signed_cast_skid_if #(.IN_WIDTH(8), .OUT_WIDTH(4)) if3 ();
  fixed_signed_cast_skid_if #(.IN_WIDTH(4), .OUT_WIDTH(8)) if4 ();

  fixed_signed_cast_skid #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(4),
                           .SYMMETRIC(1'b0), .ROUND_FLOOR(1'b1))
    u_id (.clk(clk), .rst(rst), .io(if0));
  fixed_signed_cast_skid #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(2),
                           .SYMMETRIC(1'b0), .ROUND_FLOOR(1'b1))
    u_floor (.clk(clk), .rst(rst), .io(if1));
  fixed_signed_cast_skid #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(2),
                           .SYMMETRIC(1'b0), .ROUND_FLOOR(1'b0))
    u_round (.clk(clk), .rst(rst), .io(if2));
  fixed_signed_cast_skid #(.IN_WIDTH(8), .IN_FRAC_WIDTH(4), .OUT_WIDTH(4), .OUT_FRAC_WIDTH(2),
                           .SYMMETRIC(1'b1), .ROUND_FLOOR(1'b1))
    u_sym (.clk(clk), .rst(rst), .io(if3));
  fixed_signed_cast_skid #(.IN_WIDTH(4), .IN_FRAC_WIDTH(2), .OUT_WIDTH(8), .OUT_FRAC_WIDTH(4),
                           .SYMMETRIC(1'b0), .ROUND_FLOOR(1'b1))
    u_widen (.clk(clk), .rst(rst), .io(if4));

  typedef struct {
    int         sel;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t vecs [NVEC];

  task automatic drive(input logic [7:0] d, input logic v, input logic r);
    if0.data_in = d;      if0.data_in_valid = v; if0.data_out_ready = r;
    if1.data_in = d;      if1.data_in_valid = v; if1.data_out_ready = r;
    if2.data_in = d;      if2.data_in_valid = v; if2.data_out_ready = r;
    if3.data_in = d;      if3.data_in_valid = v; if3.data_out_ready = r;
    if4.data_in = d[3:0]; if4.data_in_valid = v; if4.data_out_ready = r;
  endtask

  task automatic get_out(input int sel, output logic [7:0] d, output logic v, output logic r);
    case (sel)
      0:       begin d = if0.data_out;         v = if0.data_out_valid; r = if0.data_in_ready; end
      1:       begin d = {4'h0, if1.data_out}; v = if1.data_out_valid; r = if1.data_in_ready; end
      2:       begin d = {4'h0, if2.data_out}; v = if2.data_out_valid; r = if2.data_in_ready; end
      3:       begin d = {4'h0, if3.data_out}; v = if3.data_out_valid; r = if3.data_in_ready; end
      default: begin d = if4.data_out;         v = if4.data_out_valid; r = if4.data_in_ready; end
    endcase
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic [7:0] d;
    logic       v;
    logic       r;

    vecs[0]  = '{0, 8'h00, 8'h00};
    vecs[1]  = '{0, 8'h7F, 8'h7F};
    vecs[2]  = '{0, 8'h80, 8'h80};
    vecs[3]  = '{0, 8'hA5, 8'hA5};
    vecs[4]  = '{1, 8'h7F, 8'h07};
    vecs[5]  = '{1, 8'h80, 8'h08};
    vecs[6]  = '{1, 8'h03, 8'h00};
    vecs[7]  = '{1, 8'hFD, 8'h0F};
    vecs[8]  = '{1, 8'h14, 8'h05};
    vecs[9]  = '{2, 8'h02, 8'h01};
    vecs[10] = '{2, 8'h01, 8'h00};
    vecs[11] = '{2, 8'hFE, 8'h00};
    vecs[12] = '{2, 8'h7F, 8'h07};
    vecs[13] = '{2, 8'hFD, 8'h0F};
    vecs[14] = '{3, 8'h80, 8'h09};
    vecs[15] = '{3, 8'hE0, 8'h09};
    vecs[16] = '{3, 8'h7F, 8'h07};
    vecs[17] = '{3, 8'hE8, 8'h0A};
    vecs[18] = '{4, 8'h07, 8'h1C};
    vecs[19] = '{4, 8'h08, 8'hE0};
    vecs[20] = '{4, 8'h01, 8'h04};

    drive(8'h00, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int s = 0; s < 5; s += 4) begin
      get_out(s, d, v, r);
      check($sformatf("reset_valid_%0d", s), {7'd0, v}, 8'h00);
      check($sformatf("reset_data_%0d", s), d, 8'h00);
      check($sformatf("reset_ready_%0d", s), {7'd0, r}, 8'h01);
    end

    // Back-to-back stream; each result must appear one cycle after its transfer.
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].din, 1'b1, 1'b1);
      @(negedge clk);
      get_out(vecs[i].sel, d, v, r);
      check($sformatf("vec%0d_valid", i), {7'd0, v}, 8'h01);
      check($sformatf("vec%0d_data", i), d, vecs[i].exp);
    end
    drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    get_out(0, d, v, r);
    check("drain_valid", {7'd0, v}, 8'h00);

    // Fill both entries with the output stalled.
    drive(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    get_out(0, d, v, r);
    check("fill1_ready", {7'd0, r}, 8'h01);
    check("fill1_data", d, 8'h11);
    drive(8'h22, 1'b1, 1'b0);
    @(negedge clk);
    get_out(0, d, v, r);
    check("fill2_ready", {7'd0, r}, 8'h00);
    check("fill2_data", d, 8'h11);
    drive(8'h33, 1'b1, 1'b0);
    @(negedge clk);
    get_out(0, d, v, r);
    check("stall_ready", {7'd0, r}, 8'h00);
    check("stall_valid", {7'd0, v}, 8'h01);
    check("stall_data", d, 8'h11);

    drive(8'h00, 1'b0, 1'b1);
    @(negedge clk);
    get_out(0, d, v, r);
    check("drain1_data", d, 8'h22);
    check("drain1_valid", {7'd0, v}, 8'h01);
    check("drain1_ready", {7'd0, r}, 8'h01);
    @(negedge clk);
    get_out(0, d, v, r);
    check("drain2_valid", {7'd0, v}, 8'h00);

    // Reset while full, with an input offered in the same cycle.
    drive(8'h44, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    get_out(0, d, v, r);
    check("prerst_ready", {7'd0, r}, 8'h00);
    drive(8'h55, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(8'h00, 1'b0, 1'b0);
    @(negedge clk);
    get_out(0, d, v, r);
    check("rst_valid", {7'd0, v}, 8'h00);
    check("rst_ready", {7'd0, r}, 8'h01);
    check("rst_data", d, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
